// File: rtl/surov_pkg.sv
// rtl/surov_pkg.sv - shared fetch types, NOP constant and PC alignment helper
package surov_pkg;

    typedef logic [31:0] word_t;

    localparam word_t NOP = 32'h0000_0013;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch stage bus: memory read port, redirect input and decode output
interface fetch_queue_if;
    import surov_pkg::*;

    logic  mem_req_valid;
    logic  mem_req_ready;
    word_t mem_req_addr;
    logic  mem_rsp_valid;
    word_t mem_rsp_data;
    logic  redirect_valid;
    word_t redirect_pc;
    logic  out_valid;
    logic  out_ready;
    word_t out_instr;
    word_t out_pc;

    modport master (
        output mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// rtl/fetch_queue_sync_fifo.sv - register-based FIFO with flush; head is read combinationally from storage
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full));
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch: PC, credit-limited read issue, response FIFO, redirect squash
module fetch_queue
    import surov_pkg::*;
#(
    parameter int    DEPTH    = 2,
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master fq
);
    localparam int CW = $clog2(DEPTH + 1);

    word_t         pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] entry_count;
    logic [CW-1:0] pc_count;
    logic [CW:0]   used;
    logic          entry_full;
    logic          entry_empty;
    logic          pc_full;
    logic          pc_empty;
    logic          redirect;
    logic          rsp;
    logic          issue;
    logic          accept;
    logic          rsp_keep;
    logic          out_valid;
    logic          pop;
    word_t         req_pc;
    fetch_entry_t  entry_in;
    fetch_entry_t  head;

    assign redirect  = fq.redirect_valid;
    assign rsp       = fq.mem_rsp_valid;
    // Credits cover queued entries plus live (non-squashed) reads in flight.
    assign used      = {1'b0, entry_count} + {1'b0, inflight} - {1'b0, drop};
    assign issue     = !rst && !redirect && (used < (CW+1)'(DEPTH));
    assign accept    = issue && fq.mem_req_ready;
    assign rsp_keep  = rsp && (drop == '0) && !redirect;
    assign out_valid = !entry_empty && !redirect;
    assign pop       = out_valid && fq.out_ready;

    assign entry_in.instr = fq.mem_rsp_data;
    assign entry_in.pc    = req_pc;

    assign fq.mem_req_valid = issue;
    assign fq.mem_req_addr  = pc;
    assign fq.out_valid     = out_valid;
    assign fq.out_instr     = out_valid ? head.instr : NOP;
    assign fq.out_pc        = out_valid ? head.pc : pc;

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) entry_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .pop   (pop),
        .flush (redirect),
        .wdata (entry_in),
        .rdata (head),
        .full  (entry_full),
        .empty (entry_empty),
        .count (entry_count)
    );

    sync_fifo #(.WIDTH($bits(word_t)), .DEPTH(DEPTH)) pc_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (rsp_keep),
        .flush (redirect),
        .wdata (pc),
        .rdata (req_pc),
        .full  (pc_full),
        .empty (pc_empty),
        .count (pc_count)
    );

    // A redirect squashes every read still in flight except the one answering this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else if (redirect) begin
            pc       <= align_word(fq.redirect_pc);
            inflight <= inflight - CW'(rsp);
            drop     <= inflight - CW'(rsp);
        end else begin
            if (accept) pc <= pc + 32'd4;
            inflight <= inflight + CW'(accept) - CW'(rsp);
            if (rsp && drop != '0) drop <= drop - CW'(1);
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (used <= (CW+1)'(DEPTH));
            assert (!(rsp && inflight == '0));
            assert (drop <= inflight);
            assert (pc_count == inflight - drop);
            assert (!(accept && pc_full));
            assert (!(rsp_keep && pc_empty));
            assert (!(rsp_keep && entry_full));
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed bench for fetch_queue with an in-order 1-cycle memory model
module tb_fetch_queue;
    import surov_pkg::*;

    localparam word_t KEY = 32'h1357_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    word_t        mq[$];
    word_t        acc_log[$];
    fetch_entry_t beat_log[$];
    logic         s_acc = 1'b0;
    logic         s_fired = 1'b0;
    word_t        s_addr = '0;

    task automatic check_eq(input string tag, input word_t got, input word_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_beats(input int n, input string tag);
        int budget = 0;
        while (beat_log.size() < n && budget < 30) begin
            tick();
            budget++;
        end
        check_eq(tag, word_t'(beat_log.size() >= n), 32'd1);
    endtask

    task automatic check_beat(input int idx, input word_t exp_pc, input string tag);
        if (beat_log.size() > idx) begin
            check_eq({tag, "_pc"}, beat_log[idx].pc, exp_pc);
            check_eq({tag, "_instr"}, beat_log[idx].instr, exp_pc ^ KEY);
        end else begin
            check_eq({tag, "_missing"}, word_t'(beat_log.size()), word_t'(idx + 1));
        end
    endtask

    task automatic check_acc(input int idx, input word_t exp_addr, input string tag);
        if (acc_log.size() > idx) check_eq(tag, acc_log[idx], exp_addr);
        else check_eq({tag, "_missing"}, word_t'(acc_log.size()), word_t'(idx + 1));
    endtask

    // Sample handshakes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        fetch_entry_t e;
        s_acc   = bus.mem_req_valid && bus.mem_req_ready;
        s_addr  = bus.mem_req_addr;
        s_fired = bus.mem_rsp_valid;
        if (!rst) begin
            if (s_acc) acc_log.push_back(s_addr);
            if (bus.out_valid && bus.out_ready) begin
                e.instr = bus.out_instr;
                e.pc    = bus.out_pc;
                beat_log.push_back(e);
            end
        end
    end

    // In-order memory: answers the cycle after accept unless held.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            mq.delete();
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = '0;
        end else begin
            if (s_fired && mq.size() > 0) void'(mq.pop_front());
            if (s_acc) mq.push_back(s_addr);
            bus.mem_rsp_valid = !hold && (mq.size() > 0);
            bus.mem_rsp_data  = (mq.size() > 0) ? (mq[0] ^ KEY) : '0;
        end
    end

    initial begin
        int    found;
        bus.mem_req_ready  = 1'b1;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        rst = 1'b1;
        ticks(2);

        check_eq("rst_req_valid", bus.mem_req_valid, 32'd0);
        check_eq("rst_out_valid", bus.out_valid, 32'd0);
        check_eq("rst_out_instr", bus.out_instr, NOP);
        check_eq("rst_out_pc", bus.out_pc, 32'h0);

        rst = 1'b0;
        #1;
        check_eq("first_req_valid", bus.mem_req_valid, 32'd1);
        check_eq("first_req_addr", bus.mem_req_addr, 32'h0);
        tick();
        check_eq("latency_out_valid", bus.out_valid, 32'd0);
        check_eq("latency_nop", bus.out_instr, NOP);
        tick();
        check_eq("first_out_valid", bus.out_valid, 32'd1);
        check_eq("first_out_pc", bus.out_pc, 32'h0);
        check_eq("first_out_instr", bus.out_instr, 32'h0 ^ KEY);

        ticks(4);
        check_eq("credit_stall_req", bus.mem_req_valid, 32'd0);
        check_eq("credit_stall_count", word_t'(acc_log.size()), 32'd2);
        check_eq("credit_head_pc", bus.out_pc, 32'h0);

        bus.out_ready = 1'b1;
        ticks(12);
        check_acc(0, 32'h0, "acc0");
        check_acc(1, 32'h4, "acc1");
        check_acc(2, 32'h8, "resume_acc");
        check_beat(0, 32'h0, "beat0");
        check_beat(1, 32'h4, "beat1");
        check_beat(2, 32'h8, "beat2");

        // Two reads stalled in memory, then redirect to 0x100.
        hold = 1'b1;
        ticks(8);
        check_eq("hold_req_valid", bus.mem_req_valid, 32'd0);
        check_eq("hold_out_valid", bus.out_valid, 32'd0);
        check_eq("hold_inflight", word_t'(mq.size()), 32'd2);
        beat_log.delete();
        acc_log.delete();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        hold = 1'b0;
        #1;
        check_eq("redir_t_req_valid", bus.mem_req_valid, 32'd0);
        check_eq("redir_t_out_valid", bus.out_valid, 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("redir_t1_req_valid", bus.mem_req_valid, 32'd1);
        check_eq("redir_t1_req_addr", bus.mem_req_addr, 32'h100);
        wait_beats(2, "redir_beats_timeout");
        check_beat(0, 32'h100, "redir_beat0");
        check_beat(1, 32'h104, "redir_beat1");

        // Redirect landing on a response and a decode pop.
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (bus.out_valid && bus.mem_rsp_valid && !bus.mem_req_valid) found = 1;
        end
        check_eq("coinc_found", word_t'(found), 32'd1);
        beat_log.delete();
        acc_log.delete();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        #1;
        check_eq("coinc_out_valid", bus.out_valid, 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        check_eq("coinc_no_pop", word_t'(beat_log.size()), 32'd0);
        #1;
        check_eq("coinc_issue_now", bus.mem_req_valid, 32'd1);
        wait_beats(1, "coinc_beats_timeout");
        check_beat(0, 32'h300, "coinc_beat0");

        // PC wrap and redirect alignment.
        acc_log.delete();
        beat_log.delete();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("wrap_addr", bus.mem_req_addr, 32'hFFFF_FFFC);
        ticks(6);
        check_acc(0, 32'hFFFF_FFFC, "wrap_acc0");
        check_acc(1, 32'h0, "wrap_acc1");
        wait_beats(2, "wrap_beats_timeout");
        check_beat(0, 32'hFFFF_FFFC, "wrap_beat0");
        check_beat(1, 32'h0, "wrap_beat1");

        acc_log.delete();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h203;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check_eq("align_addr", bus.mem_req_addr, 32'h200);
        ticks(3);
        check_acc(0, 32'h200, "align_acc0");

        // Asynchronous reset with entries queued.
        bus.out_ready = 1'b0;
        ticks(8);
        check_eq("pre_rst_out_valid", bus.out_valid, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_out_valid", bus.out_valid, 32'd0);
        check_eq("async_rst_out_instr", bus.out_instr, NOP);
        check_eq("async_rst_out_pc", bus.out_pc, 32'h0);
        check_eq("async_rst_req_valid", bus.mem_req_valid, 32'd0);
        ticks(2);
        acc_log.delete();
        beat_log.delete();
        bus.out_ready = 1'b1;
        rst = 1'b0;
        ticks(8);
        check_acc(0, 32'h0, "restart_acc0");
        check_beat(0, 32'h0, "restart_beat0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
